// File: rtl/rv32i_regfile_pkg.sv
// ============================================================================
// Module   : rv32i_regfile_pkg
// Purpose  : Shared widths and types for the RV32I register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_regfile_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int AW       = $clog2(NUM_REGS);

  typedef logic [XLEN-1:0] word_t;
  typedef logic [AW-1:0]   reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage : rv32i_regfile_pkg

`default_nettype wire

// File: rtl/rv32i_regfile_rdport.sv
// ============================================================================
// Module   : rv32i_regfile_rdport
// Purpose  : Combinational read port; forces x0 to zero and, with
//            WRITE_BYPASS_EN defined, forwards same-cycle write data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_regfile_rdport
  import rv32i_regfile_pkg::*;
(
  input  logic [AW-1:0]   raddr_i,
  input  word_t           regs_i [1:NUM_REGS-1],
`ifdef WRITE_BYPASS_EN
  input  logic            byp_en_i,
  input  logic [AW-1:0]   byp_addr_i,
  input  logic [XLEN-1:0] byp_data_i,
`endif
  output logic [XLEN-1:0] rdata_o
);

  always_comb begin
    rdata_o = '0;
    if (raddr_i != REG_ZERO) begin
`ifdef WRITE_BYPASS_EN
      if (byp_en_i && (byp_addr_i == raddr_i))
        rdata_o = byp_data_i;
      else
`endif
        rdata_o = regs_i[raddr_i];
    end
  end

endmodule : rv32i_regfile_rdport

`default_nettype wire

// File: rtl/rv32i_regfile.sv
// ============================================================================
// Module   : rv32i_regfile
// Purpose  : 32 x 32-bit RV32I GPR file, two async reads, one sync write.
//            Optional write-through forwarding via macro WRITE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_regfile
  import rv32i_regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  output logic [XLEN-1:0] rd1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd2,
  input  logic            write,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  // x0 has no storage; the read ports synthesise its zero value.
  word_t regs_q [1:NUM_REGS-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++)
        regs_q[i] <= '0;
    end else if (write && (wa != REG_ZERO)) begin
      regs_q[wa] <= wd;
    end
  end

`ifdef WRITE_BYPASS_EN
  logic w_byp_en;
  assign w_byp_en = write && (wa != REG_ZERO);
`endif

  rv32i_regfile_rdport u_rdport1 (
    .raddr_i    (ra1),
    .regs_i     (regs_q),
`ifdef WRITE_BYPASS_EN
    .byp_en_i   (w_byp_en),
    .byp_addr_i (wa),
    .byp_data_i (wd),
`endif
    .rdata_o    (rd1)
  );

  rv32i_regfile_rdport u_rdport2 (
    .raddr_i    (ra2),
    .regs_i     (regs_q),
`ifdef WRITE_BYPASS_EN
    .byp_en_i   (w_byp_en),
    .byp_addr_i (wa),
    .byp_data_i (wd),
`endif
    .rdata_o    (rd2)
  );

endmodule : rv32i_regfile

`default_nettype wire

// File: tb/tb_rv32i_regfile.sv
// ============================================================================
// Module   : tb_rv32i_regfile
// Purpose  : Scoreboard-driven self-checking bench for rv32i_regfile
//            (expectations follow WRITE_BYPASS_EN when it is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32i_regfile;
  import rv32i_regfile_pkg::*;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   ra1;
  logic [XLEN-1:0] rd1;
  logic [AW-1:0]   ra2;
  logic [XLEN-1:0] rd2;
  logic            write;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] wd;

  word_t model [NUM_REGS];
  word_t exp_q [$];
  int    pass_cnt;
  int    total_cnt;

  rv32i_regfile dut (
    .clk   (clk),
    .rst   (rst),
    .ra1   (ra1),
    .rd1   (rd1),
    .ra2   (ra2),
    .rd2   (rd2),
    .write (write),
    .wa    (wa),
    .wd    (wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One write, presented at the falling edge and committed at the next rising edge.
  task automatic do_write(input logic [AW-1:0] a, input word_t d, input logic en);
    @(negedge clk);
    write = en;
    wa    = a;
    wd    = d;
    @(posedge clk);
    #1;
    write = 1'b0;
    if (en && a != 0) model[a] = d;
  endtask

  task automatic test_reset();
    word_t e;
    // Reset held across a write edge: the reset must win.
    @(negedge clk);
    write = 1'b1; wa = 5'd3; wd = 32'hCAFEF00D;
    rst = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      ra1 = AW'(i);
      ra2 = AW'(NUM_REGS - i);
      exp_q.push_back(model[i]);
      exp_q.push_back(model[NUM_REGS - i]);
      #1;
      e = exp_q.pop_front();
      total_cnt++;
      if (rd1 !== e) $display("FAIL reset_rd1 x%0d: got %h expected %h", i, rd1, e);
      else pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++;
      if (rd2 !== e) $display("FAIL reset_rd2 x%0d: got %h expected %h", NUM_REGS - i, rd2, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_write_read();
    word_t e;
    do_write(5'd5, 32'hDEADBEEF, 1'b1);
    ra1 = 5'd5;
    ra2 = 5'd5;
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    #1;
    e = exp_q.pop_front();
    total_cnt++;
    if (rd1 !== e) $display("FAIL write_read_rd1: got %h expected %h", rd1, e);
    else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++;
    if (rd2 !== e) $display("FAIL write_read_rd2: got %h expected %h", rd2, e);
    else pass_cnt++;
  endtask

  task automatic test_x0_write();
    word_t e;
    do_write(5'd0, 32'hFFFFFFFF, 1'b1);
    ra1 = 5'd0;
    ra2 = 5'd0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front();
    total_cnt++;
    if (rd1 !== e) $display("FAIL x0_rd1: got %h expected %h", rd1, e);
    else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++;
    if (rd2 !== e) $display("FAIL x0_rd2: got %h expected %h", rd2, e);
    else pass_cnt++;
  endtask

  task automatic test_write_disabled();
    word_t e;
    do_write(5'd7, 32'h12345678, 1'b0);
    ra1 = 5'd7;
    ra2 = 5'd5;
    exp_q.push_back(model[7]);
    exp_q.push_back(model[5]);
    #1;
    e = exp_q.pop_front();
    total_cnt++;
    if (rd1 !== e) $display("FAIL write_disabled_x7: got %h expected %h", rd1, e);
    else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++;
    if (rd2 !== e) $display("FAIL write_disabled_x5: got %h expected %h", rd2, e);
    else pass_cnt++;
  endtask

  task automatic test_random_sweep();
    word_t e;
    word_t v;
    for (int round = 0; round < 10; round++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        v = $urandom;
        do_write(AW'(r), v, 1'b1);
        if ($urandom_range(0, 1) == 0) begin
          ra1 = AW'(r);
          exp_q.push_back(model[r]);
          #1;
          e = exp_q.pop_front();
          total_cnt++;
          if (rd1 !== e) $display("FAIL sweep_rd1 round %0d x%0d: got %h expected %h", round, r, rd1, e);
          else pass_cnt++;
        end else begin
          ra2 = AW'(r);
          exp_q.push_back(model[r]);
          #1;
          e = exp_q.pop_front();
          total_cnt++;
          if (rd2 !== e) $display("FAIL sweep_rd2 round %0d x%0d: got %h expected %h", round, r, rd2, e);
          else pass_cnt++;
        end
      end
      // Full readback confirms no write disturbed another register.
      for (int i = 0; i < NUM_REGS; i++) begin
        ra1 = AW'(i);
        ra2 = AW'(NUM_REGS - 1 - i);
        exp_q.push_back(model[i]);
        exp_q.push_back(model[NUM_REGS - 1 - i]);
        #1;
        e = exp_q.pop_front();
        total_cnt++;
        if (rd1 !== e) $display("FAIL sweep_hold_rd1 round %0d x%0d: got %h expected %h", round, i, rd1, e);
        else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++;
        if (rd2 !== e) $display("FAIL sweep_hold_rd2 round %0d x%0d: got %h expected %h", round, NUM_REGS - 1 - i, rd2, e);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_write_cycle_read();
    word_t e;
    @(negedge clk);
    ra1   = 5'd9;
    ra2   = 5'd0;
    write = 1'b1;
    wa    = 5'd9;
    wd    = 32'hA5A5A5A5;
`ifdef WRITE_BYPASS_EN
    exp_q.push_back(32'hA5A5A5A5);
`else
    exp_q.push_back(model[9]);
`endif
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front();
    total_cnt++;
    if (rd1 !== e) $display("FAIL same_cycle_rd1: got %h expected %h", rd1, e);
    else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++;
    if (rd2 !== e) $display("FAIL same_cycle_x0_rd2: got %h expected %h", rd2, e);
    else pass_cnt++;
    @(posedge clk);
    #1;
    write = 1'b0;
    model[9] = 32'hA5A5A5A5;
    exp_q.push_back(model[9]);
    #1;
    e = exp_q.pop_front();
    total_cnt++;
    if (rd1 !== e) $display("FAIL after_edge_rd1: got %h expected %h", rd1, e);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst   = 1'b1;
    ra1   = '0;
    ra2   = '0;
    write = 1'b0;
    wa    = '0;
    wd    = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_write_read();
    test_x0_write();
    test_write_disabled();
    test_random_sweep();
    test_write_cycle_read();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_rv32i_regfile

`default_nettype wire
